// File: rtl/matrix_pkg.sv
// Shared types and constants for the matrix ALU sequencer.
package matrix_pkg;

   localparam int ELEM_W    = 16;
   localparam int MAX_DIM   = 5;
   localparam int NUM_SLOTS = 3;

   // The only 2-bit slot index that does not name a real slot.
   localparam logic [1:0] BAD_SLOT = 2'(NUM_SLOTS);

   typedef enum logic [1:0] {
      OP_ADD       = 2'd0,
      OP_SCALE     = 2'd1,
      OP_TRANSPOSE = 2'd2,
      OP_RSVD      = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      ERR_NONE     = 3'd0,
      ERR_SLOT     = 3'd1,
      ERR_DIMS     = 3'd2,
      ERR_MISMATCH = 3'd3,
      ERR_ALIAS    = 3'd4,
      ERR_OP       = 3'd5
   } err_e;

   typedef enum logic [3:0] {
      ST_IDLE, ST_LD_A, ST_LD_B, ST_CHECK,
      ST_RD_A, ST_RD_B, ST_WR, ST_DIM_WR, ST_DONE
   } state_e;

   // A dimension is usable when it is between 1 and MAX_DIM.
   function automatic logic dim_ok(input logic [2:0] d);
      return (d != 3'd0) && (d <= 3'(MAX_DIM));
   endfunction

endpackage

// File: rtl/matrix_elem_counter.sv
// Row-major (row, col) iterator over an m x n matrix.
module matrix_elem_counter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       inc,
   input  logic [2:0] m,
   input  logic [2:0] n,
   output logic [2:0] row,
   output logic [2:0] col,
   output logic       last
);

   logic [2:0] row_q, row_d;
   logic [2:0] col_q, col_d;

   assign row  = row_q;
   assign col  = col_q;
   assign last = (row_q == m - 3'd1) && (col_q == n - 3'd1);

   // Next position: clear wins, otherwise step col and wrap into the next row.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      row_d = row_q;
      col_d = col_q;
      if (clr) begin
         row_d = 3'd0;
         col_d = 3'd0;
      end else if (inc) begin
         if (col_q == n - 3'd1) begin
            col_d = 3'd0;
            row_d = row_q + 3'd1;
         end else begin
            col_d = col_q + 3'd1;
         end
      end
   end

   // Position registers.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         row_q <= 3'd0;
         col_q <= 3'd0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end

endmodule

// File: rtl/matrix_op_sequencer.sv
// Sequences one element-wise matrix op (add, scale, transpose) through the memory ALU port.
module matrix_op_sequencer
   import matrix_pkg::*;
#(
   parameter int DW = ELEM_W
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [1:0]    op,
   input  logic [1:0]    src_a_slot,
   input  logic [1:0]    src_b_slot,
   input  logic [1:0]    dst_slot,
   input  logic [DW-1:0] scalar,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [2:0]    err_code,
   output logic [1:0]    alu_rd_slot,
   output logic [2:0]    alu_rd_row,
   output logic [2:0]    alu_rd_col,
   input  logic [DW-1:0] alu_rd_data,
   input  logic [2:0]    alu_current_m,
   input  logic [2:0]    alu_current_n,
   output logic [1:0]    alu_wr_slot,
   output logic [2:0]    alu_wr_row,
   output logic [2:0]    alu_wr_col,
   output logic [DW-1:0] alu_wr_data,
   output logic          alu_wr_we,
   output logic [2:0]    alu_res_m,
   output logic [2:0]    alu_res_n,
   output logic          alu_dim_we
);

   state_e        state_q, state_d;
   op_e           op_q, op_d;
   logic [1:0]    sa_q, sa_d, sb_q, sb_d, sd_q, sd_d;
   logic [DW-1:0] scalar_q, scalar_d, a_q, a_d, b_q, b_d;
   logic [2:0]    m_a_q, m_a_d, n_a_q, n_a_d, m_b_q, m_b_d, n_b_q, n_b_d;
   logic          err_q, err_d;
   err_e          err_code_q, err_code_d, chk_code;
   logic [1:0]    rd_slot_q;
   logic [2:0]    rd_row_q, rd_col_q;
   logic [2:0]    row, col;
   logic          last;
   logic [DW-1:0] scaled;

   matrix_elem_counter u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state_q == ST_CHECK),
      .inc   (state_q == ST_WR),
      .m     (m_a_q),
      .n     (n_a_q),
      .row   (row),
      .col   (col),
      .last  (last)
   );

   // Command validation, highest-priority fault first.
   always_comb begin
      chk_code = ERR_NONE;
      if (op_q == OP_RSVD)
         chk_code = ERR_OP;
      else if (sa_q == BAD_SLOT || sd_q == BAD_SLOT || (op_q == OP_ADD && sb_q == BAD_SLOT))
         chk_code = ERR_SLOT;
      else if (!dim_ok(m_a_q) || !dim_ok(n_a_q))
         chk_code = ERR_DIMS;
      else if (op_q == OP_ADD && (m_b_q != m_a_q || n_b_q != n_a_q))
         chk_code = ERR_MISMATCH;
      else if (op_q == OP_TRANSPOSE && sd_q == sa_q)
         chk_code = ERR_ALIAS;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start) state_d = ST_LD_A;
         ST_LD_A:   state_d = ST_LD_B;
         ST_LD_B:   state_d = ST_CHECK;
         ST_CHECK:  state_d = (chk_code != ERR_NONE) ? ST_DONE : ST_RD_A;
         ST_RD_A:   state_d = (op_q == OP_ADD) ? ST_RD_B : ST_WR;
         ST_RD_B:   state_d = ST_WR;
         ST_WR:     state_d = last ? ST_DIM_WR : ST_RD_A;
         ST_DIM_WR: state_d = ST_DONE;
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Datapath latches: command at acceptance, dims in the load states, operands in the read states.
   always_comb begin
      op_d       = op_q;
      sa_d       = sa_q;
      sb_d       = sb_q;
      sd_d       = sd_q;
      scalar_d   = scalar_q;
      m_a_d      = m_a_q;
      n_a_d      = n_a_q;
      m_b_d      = m_b_q;
      n_b_d      = n_b_q;
      a_d        = a_q;
      b_d        = b_q;
      err_d      = err_q;
      err_code_d = err_code_q;
      case (state_q)
         ST_IDLE: if (start) begin
            op_d       = op_e'(op);
            sa_d       = src_a_slot;
            sb_d       = src_b_slot;
            sd_d       = dst_slot;
            scalar_d   = scalar;
            err_d      = 1'b0;
            err_code_d = ERR_NONE;
         end
         ST_LD_A: begin
            m_a_d = alu_current_m;
            n_a_d = alu_current_n;
         end
         ST_LD_B: begin
            m_b_d = alu_current_m;
            n_b_d = alu_current_n;
         end
         ST_CHECK: if (chk_code != ERR_NONE) begin
            err_d      = 1'b1;
            err_code_d = chk_code;
         end
         ST_RD_A: a_d = alu_rd_data;
         ST_RD_B: b_d = alu_rd_data;
         default: ;
      endcase
   end

   // Datapath registers; the read-address hold registers track the last driven address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q       <= OP_ADD;
         sa_q       <= 2'd0;
         sb_q       <= 2'd0;
         sd_q       <= 2'd0;
         scalar_q   <= '0;
         m_a_q      <= 3'd0;
         n_a_q      <= 3'd0;
         m_b_q      <= 3'd0;
         n_b_q      <= 3'd0;
         a_q        <= '0;
         b_q        <= '0;
         err_q      <= 1'b0;
         err_code_q <= ERR_NONE;
         rd_slot_q  <= 2'd0;
         rd_row_q   <= 3'd0;
         rd_col_q   <= 3'd0;
      end else begin
         op_q       <= op_d;
         sa_q       <= sa_d;
         sb_q       <= sb_d;
         sd_q       <= sd_d;
         scalar_q   <= scalar_d;
         m_a_q      <= m_a_d;
         n_a_q      <= n_a_d;
         m_b_q      <= m_b_d;
         n_b_q      <= n_b_d;
         a_q        <= a_d;
         b_q        <= b_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
         rd_slot_q  <= alu_rd_slot;
         rd_row_q   <= alu_rd_row;
         rd_col_q   <= alu_rd_col;
      end
   end

   assign scaled = a_q * scalar_q;

   // Output decode from the current state.
   always_comb begin
      busy        = (state_q != ST_IDLE);
      done        = (state_q == ST_DONE);
      err         = err_q;
      err_code    = err_code_q;
      alu_rd_slot = rd_slot_q;
      alu_rd_row  = rd_row_q;
      alu_rd_col  = rd_col_q;
      alu_wr_slot = 2'd0;
      alu_wr_row  = 3'd0;
      alu_wr_col  = 3'd0;
      alu_wr_data = '0;
      alu_wr_we   = 1'b0;
      alu_res_m   = 3'd0;
      alu_res_n   = 3'd0;
      alu_dim_we  = 1'b0;
      case (state_q)
         ST_LD_A: alu_rd_slot = sa_q;
         ST_LD_B: alu_rd_slot = sb_q;
         ST_RD_A: begin
            alu_rd_slot = sa_q;
            alu_rd_row  = row;
            alu_rd_col  = col;
         end
         ST_RD_B: begin
            alu_rd_slot = sb_q;
            alu_rd_row  = row;
            alu_rd_col  = col;
         end
         ST_WR: begin
            alu_wr_we   = 1'b1;
            alu_wr_slot = sd_q;
            alu_wr_row  = (op_q == OP_TRANSPOSE) ? col : row;
            alu_wr_col  = (op_q == OP_TRANSPOSE) ? row : col;
            case (op_q)
               OP_ADD:   alu_wr_data = a_q + b_q;
               OP_SCALE: alu_wr_data = scaled;
               default:  alu_wr_data = a_q;
            endcase
         end
         ST_DIM_WR: begin
            alu_dim_we  = 1'b1;
            alu_wr_slot = sd_q;
            alu_res_m   = (op_q == OP_TRANSPOSE) ? n_a_q : m_a_q;
            alu_res_n   = (op_q == OP_TRANSPOSE) ? m_a_q : n_a_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Directed bench: a behavioural 3-slot matrix memory plus a table of commands with hand-computed results.
module tb_matrix_op_sequencer;
   import matrix_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'd0, src_a_slot = 2'd0, src_b_slot = 2'd0, dst_slot = 2'd0;
   logic [15:0] scalar = 16'd0;
   logic        busy, done, err;
   logic [2:0]  err_code;
   logic [1:0]  alu_rd_slot, alu_wr_slot;
   logic [2:0]  alu_rd_row, alu_rd_col, alu_wr_row, alu_wr_col;
   logic [15:0] alu_rd_data, alu_wr_data;
   logic [2:0]  alu_current_m, alu_current_n, alu_res_m, alu_res_n;
   logic        alu_wr_we, alu_dim_we;

   matrix_op_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op),
      .src_a_slot(src_a_slot), .src_b_slot(src_b_slot), .dst_slot(dst_slot), .scalar(scalar),
      .busy(busy), .done(done), .err(err), .err_code(err_code),
      .alu_rd_slot(alu_rd_slot), .alu_rd_row(alu_rd_row), .alu_rd_col(alu_rd_col),
      .alu_rd_data(alu_rd_data), .alu_current_m(alu_current_m), .alu_current_n(alu_current_n),
      .alu_wr_slot(alu_wr_slot), .alu_wr_row(alu_wr_row), .alu_wr_col(alu_wr_col),
      .alu_wr_data(alu_wr_data), .alu_wr_we(alu_wr_we),
      .alu_res_m(alu_res_m), .alu_res_n(alu_res_n), .alu_dim_we(alu_dim_we)
   );

   always #5 clk = ~clk;

   // ---------------- memory model ----------------
   logic [15:0] mem [3][25];
   logic [2:0]  dm [3];
   logic [2:0]  dn [3];
   int wr_cnt = 0, dim_cnt = 0, both_cnt = 0;

   always_comb begin
      alu_rd_data   = 16'h0;
      alu_current_m = 3'd0;
      alu_current_n = 3'd0;
      if (alu_rd_slot != 2'd3) begin
         alu_current_m = dm[alu_rd_slot];
         alu_current_n = dn[alu_rd_slot];
         if (alu_rd_row < 3'd5 && alu_rd_col < 3'd5)
            alu_rd_data = mem[alu_rd_slot][int'(alu_rd_row) * 5 + int'(alu_rd_col)];
      end
   end

   always @(posedge clk) begin
      if (alu_wr_we && alu_dim_we) both_cnt++;
      if (alu_wr_we) begin
         wr_cnt++;
         if (alu_wr_slot != 2'd3 && alu_wr_row < 3'd5 && alu_wr_col < 3'd5)
            mem[alu_wr_slot][int'(alu_wr_row) * 5 + int'(alu_wr_col)] = alu_wr_data;
      end
      if (alu_dim_we) begin
         dim_cnt++;
         if (alu_wr_slot != 2'd3) begin
            dm[alu_wr_slot] = alu_res_m;
            dn[alu_wr_slot] = alu_res_n;
         end
      end
   end

   // ---------------- checking ----------------
   int n_chk = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      string             name;
      logic [1:0]        op, sa, sb, sd;
      logic [15:0]       scalar;
      logic [2:0]        am, an;
      logic [0:8][15:0]  a;
      logic [2:0]        bm, bn;
      logic [0:8][15:0]  b;
      logic [2:0]        code;
      logic [2:0]        rm, rn;
      logic [0:8][15:0]  c;
      int                done_cyc;
   } vec_t;

   vec_t vt[10];

   task automatic preload(input vec_t v);
      for (int s = 0; s < 3; s++) begin
         dm[s] = 3'd0;
         dn[s] = 3'd0;
         for (int i = 0; i < 25; i++) mem[s][i] = 16'h0;
      end
      if (v.sa != 2'd3) begin
         dm[v.sa] = v.am;
         dn[v.sa] = v.an;
         if (v.am <= 3'd5 && v.an <= 3'd5)
            for (int r = 0; r < int'(v.am); r++)
               for (int c = 0; c < int'(v.an); c++)
                  mem[v.sa][r * 5 + c] = v.a[r * int'(v.an) + c];
      end
      if (v.op == OP_ADD && v.sb != 2'd3 && v.sb != v.sa) begin
         dm[v.sb] = v.bm;
         dn[v.sb] = v.bn;
         for (int r = 0; r < int'(v.bm); r++)
            for (int c = 0; c < int'(v.bn); c++)
               mem[v.sb][r * 5 + c] = v.b[r * int'(v.bn) + c];
      end
   endtask

   // Presents a command so that it is accepted at the next rising edge (edge 0).
   task automatic launch(input vec_t v);
      preload(v);
      @(negedge clk);
      op = v.op; src_a_slot = v.sa; src_b_slot = v.sb; dst_slot = v.sd; scalar = v.scalar;
      start = 1'b1;
      wr_cnt = 0;
      dim_cnt = 0;
      @(posedge clk);
   endtask

   // Runs one command; if poke > 0 a second start is pulsed in that cycle and must be ignored.
   task automatic run_vec(input vec_t v, input int poke);
      int cyc, done_at, n_done;
      logic e_s, e_hold, busy_after;
      logic [2:0] code_s;
      logic ok;
      cyc = 0; done_at = -1; n_done = 0;
      e_s = 1'b0; e_hold = 1'b0; busy_after = 1'b1; code_s = 3'd0;
      launch(v);
      while (cyc < 120 && !(done_at > 0 && cyc >= done_at + 6)) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            start = 1'b0;
            op = ~v.op; src_a_slot = ~v.sa; src_b_slot = ~v.sb; dst_slot = ~v.sd; scalar = ~v.scalar;
         end
         if (poke > 0 && cyc == poke) begin
            start = 1'b1; op = OP_SCALE; src_a_slot = 2'd0; dst_slot = 2'd0; scalar = 16'd7;
         end
         if (poke > 0 && cyc == poke + 1) start = 1'b0;
         if (done) begin
            n_done++;
            if (done_at < 0) begin
               done_at = cyc; e_s = err; code_s = err_code;
            end
         end
         if (done_at > 0 && cyc == done_at + 2) begin
            e_hold = err; busy_after = busy;
         end
      end
      check({v.name, " done_cycle"}, done_at, v.done_cyc);
      check({v.name, " done_count"}, n_done, 1);
      check({v.name, " err"}, {31'd0, e_s}, {31'd0, v.code != 3'd0});
      check({v.name, " err_code"}, {29'd0, code_s}, {29'd0, v.code});
      check({v.name, " err_held"}, {31'd0, e_hold}, {31'd0, v.code != 3'd0});
      check({v.name, " busy_after"}, {31'd0, busy_after}, 32'd0);
      check({v.name, " wr_we_count"}, wr_cnt, (v.code != 3'd0) ? 0 : int'(v.rm) * int'(v.rn));
      check({v.name, " dim_we_count"}, dim_cnt, (v.code != 3'd0) ? 0 : 1);
      if (v.code == 3'd0 && v.sd != 2'd3) begin
         check({v.name, " res_m"}, {29'd0, dm[v.sd]}, {29'd0, v.rm});
         check({v.name, " res_n"}, {29'd0, dn[v.sd]}, {29'd0, v.rn});
         ok = 1'b1;
         for (int r = 0; r < int'(v.rm); r++)
            for (int c = 0; c < int'(v.rn); c++)
               if (mem[v.sd][r * 5 + c] !== v.c[r * int'(v.rn) + c]) begin
                  ok = 1'b0;
                  $display("  %s element (%0d,%0d) = %0h, expected %0h",
                           v.name, r, c, mem[v.sd][r * 5 + c], v.c[r * int'(v.rn) + c]);
               end
         check({v.name, " result_data"}, {31'd0, ok}, 32'd1);
         if (v.sd != v.sa)
            check({v.name, " src_a_intact"}, {16'd0, mem[v.sa][0]}, {16'd0, v.a[0]});
      end
   endtask

   initial begin
      //            name        op            sa    sb    sd    scalar     am    an    a                                                      bm    bn    b                                                     code  rm    rn    c                                                                         cyc
      vt[0] = '{"add",       OP_ADD,       2'd0, 2'd1, 2'd2, 16'd0,     3'd2, 3'd2, {16'd1, 16'd2, 16'd3, 16'd4, 80'd0},                   3'd2, 3'd2, {16'd10, 16'd20, 16'd30, 16'd40, 80'd0},              3'd0, 3'd2, 3'd2, {16'd11, 16'd22, 16'd33, 16'd44, 80'd0},                                   17};
      vt[1] = '{"transpose", OP_TRANSPOSE, 2'd0, 2'd1, 2'd2, 16'd0,     3'd2, 3'd3, {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 48'd0},     3'd0, 3'd0, 144'd0,                                               3'd0, 3'd3, 3'd2, {16'd1, 16'd4, 16'd2, 16'd5, 16'd3, 16'd6, 48'd0},                        17};
      vt[2] = '{"scale_wrap", OP_SCALE,    2'd0, 2'd3, 2'd1, 16'd3,     3'd1, 3'd1, {16'h8000, 128'd0},                                   3'd0, 3'd0, 144'd0,                                               3'd0, 3'd1, 3'd1, {16'h8000, 128'd0},                                                        7};
      vt[3] = '{"scale_zero", OP_SCALE,    2'd0, 2'd1, 2'd1, 16'd0,     3'd1, 3'd1, {16'h8000, 128'd0},                                   3'd0, 3'd0, 144'd0,                                               3'd0, 3'd1, 3'd1, 144'd0,                                                                    7};
      vt[4] = '{"scale_inplace", OP_SCALE, 2'd1, 2'd0, 2'd1, 16'd2,     3'd3, 3'd3, {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9}, 3'd0, 3'd0, 144'd0,                                     3'd0, 3'd3, 3'd3, {16'd2, 16'd4, 16'd6, 16'd8, 16'd10, 16'd12, 16'd14, 16'd16, 16'd18},    23};
      vt[5] = '{"err_mismatch", OP_ADD,    2'd0, 2'd1, 2'd2, 16'd0,     3'd2, 3'd2, {16'd1, 16'd2, 16'd3, 16'd4, 80'd0},                   3'd2, 3'd3, {16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 48'd0},   3'd3, 3'd0, 3'd0, 144'd0,                                                                    4};
      vt[6] = '{"err_dst_slot", OP_ADD,    2'd0, 2'd1, 2'd3, 16'd0,     3'd2, 3'd2, {16'd1, 16'd2, 16'd3, 16'd4, 80'd0},                   3'd2, 3'd2, {16'd10, 16'd20, 16'd30, 16'd40, 80'd0},              3'd1, 3'd0, 3'd0, 144'd0,                                                                    4};
      vt[7] = '{"err_alias",  OP_TRANSPOSE, 2'd1, 2'd0, 2'd1, 16'd0,    3'd2, 3'd2, {16'd1, 16'd2, 16'd3, 16'd4, 80'd0},                   3'd0, 3'd0, 144'd0,                                               3'd4, 3'd0, 3'd0, 144'd0,                                                                    4};
      vt[8] = '{"err_op_prio", OP_RSVD,    2'd0, 2'd1, 2'd3, 16'd0,     3'd2, 3'd2, {16'd1, 16'd2, 16'd3, 16'd4, 80'd0},                   3'd0, 3'd0, 144'd0,                                               3'd5, 3'd0, 3'd0, 144'd0,                                                                    4};
      vt[9] = '{"err_dims",   OP_SCALE,    2'd0, 2'd1, 2'd1, 16'd5,     3'd6, 3'd2, 144'd0,                                               3'd0, 3'd0, 144'd0,                                               3'd2, 3'd0, 3'd0, 144'd0,                                                                    4};

      // Reset state.
      repeat (2) @(negedge clk);
      check("reset busy/done/err", {29'd0, busy, done, err}, 32'd0);
      check("reset err_code", {29'd0, err_code}, 32'd0);
      check("reset we", {30'd0, alu_wr_we, alu_dim_we}, 32'd0);
      check("reset rd addr", {24'd0, alu_rd_slot, alu_rd_row, alu_rd_col}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Table of commands.
      for (int i = 0; i < 10; i++) run_vec(vt[i], 0);

      // Second start during an ADD must be ignored.
      run_vec(vt[0], 5);

      // Asynchronous reset in the middle of the element loop.
      launch(vt[0]);
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midreset outputs", {27'd0, busy, done, err, alu_wr_we, alu_dim_we}, 32'd0);
      check("midreset rd addr", {24'd0, alu_rd_slot, alu_rd_row, alu_rd_col}, 32'd0);
      repeat (3) @(negedge clk);
      check("midreset wr_we_count", wr_cnt, 1);
      check("midreset dim_we_count", dim_cnt, 0);
      check("midreset kept element", {16'd0, mem[2][0]}, 32'd11);
      check("midreset untouched element", {16'd0, mem[2][1]}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      run_vec(vt[0], 0);

      check("wr_we and dim_we overlap", both_cnt, 0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
